// File: rtl/stack_ptr_ctrl.sv
// Stack-pointer controller for the data stack (grows downward).
// Holds SP, sequences push/pop transactions to a synchronous stack memory,
// and reports full/empty/sticky-error status. The next SP on push comes from
// an external decrementer (dec_a -> dec_s).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   push, pop, wdata      request inputs, sampled only while ready=1
//   err_clr               clears the sticky err flag
//   ready, done           idle indication, one-cycle completion pulse
//   rdata                 last popped word
//   sp, empty, full, err  stack pointer and status
//   dec_a, dec_s          external decrementer operand/result
//   mem_*                 stack memory port (read data 1 cycle after mem_re)
module stack_ptr_ctrl #(
  parameter logic [13:0] SP_EMPTY = 14'h3FFF,
  parameter logic [13:0] SP_LIMIT = 14'h2000,
  parameter int unsigned DW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  input  logic          err_clr,
  output logic          ready,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic [13:0]   sp,
  output logic          empty,
  output logic          full,
  output logic          err,
  output logic [13:0]   dec_a,
  input  logic [13:0]   dec_s,
  output logic [13:0]   mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned SPW = 14;

  typedef enum logic [1:0] {IDLE, PUSH_WR, POP_RD, POP_CAP} state_e;

  state_e          state_q, state_d;
  logic [SPW-1:0]  sp_q, sp_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            we_q, we_d;
  logic            re_q, re_d;
  logic [SPW-1:0]  addr_q, addr_d;
  logic [DW-1:0]   mwdata_q, mwdata_d;

  // Combinational decodes of state and SP
  assign ready = (state_q == IDLE);
  assign empty = (sp_q == SP_EMPTY);
  assign full  = (sp_q == SP_LIMIT);
  assign dec_a = sp_q;

  assign sp        = sp_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign done      = done_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = mwdata_q;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sp_q     <= SP_EMPTY;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      addr_q   <= SP_EMPTY;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      sp_q     <= sp_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      done_q   <= done_d;
      we_q     <= we_d;
      re_q     <= re_d;
      addr_q   <= addr_d;
      mwdata_q <= mwdata_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    sp_d     = sp_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    done_d   = 1'b0;
    we_d     = 1'b0;
    re_d     = 1'b0;
    addr_d   = sp_q;
    mwdata_d = mwdata_q;

    // Clear first so that an illegal request in the same cycle wins
    if (err_clr) err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (push && pop) begin
          err_d = 1'b1;
        end else if (push) begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            sp_d     = dec_s;
            mwdata_d = wdata;
            state_d  = PUSH_WR;
          end
        end else if (pop) begin
          if (empty) begin
            err_d = 1'b1;
          end else begin
            // Strobe on entry so the read data lands in POP_CAP
            re_d    = 1'b1;
            state_d = POP_RD;
          end
        end
      end
      PUSH_WR: begin
        // addr_d defaults to sp_q, which is already the new SP here
        we_d    = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      POP_RD: begin
        state_d = POP_CAP;
      end
      POP_CAP: begin
        rdata_d = mem_rdata;
        sp_d    = SPW'(sp_q + 14'd1);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
